// File: rtl/mul_pkg.sv
// Shared types and parameter defaults for the pipelined multiplier.
package mul_pkg;

  localparam int unsigned XLEN_DEF   = 32;
  localparam int unsigned STAGES_DEF = 3;

  // Operation encoding as seen on in_op.
  typedef enum logic [1:0] {
    MUL    = 2'd0,
    MULH   = 2'd1,
    MULHSU = 2'd2,
    MULHU  = 2'd3
  } mul_op_t;

endpackage

// File: rtl/mul_pipe_reg.sv
// One pipeline stage: a valid bit plus its data word, advancing on en.
module mul_pipe_reg #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         flush,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  // Valid bit: flush wins over stall so in-flight work dies at the next edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (en) begin
      out_valid <= in_valid;
    end
  end

  // Data word: plain enabled register so synthesis is free to retime it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_data <= '0;
    end else if (en) begin
      out_data <= in_data;
    end
  end

endmodule

// File: rtl/mul_pipe.sv
// Pipelined integer multiplier (MUL/MULH/MULHSU/MULHU) with valid/ready flow
// control, flush and a configurable number of register stages.
module mul_pipe
  import mul_pkg::*;
#(
  parameter int unsigned XLEN   = XLEN_DEF,
  parameter int unsigned STAGES = STAGES_DEF
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_res,
  output logic            busy
);

  localparam int unsigned PW = 2 * XLEN;

  mul_op_t         op;
  logic            a_sx;
  logic            b_sx;
  logic [PW-1:0]   a_wide;
  logic [PW-1:0]   b_wide;
  logic [PW-1:0]   product;
  logic [XLEN-1:0] sel;
  logic            stall;
  logic            en;
  logic            accept;

  logic [STAGES-1:0] vq;
  logic [XLEN-1:0]   dq [STAGES];

  // Decode the operation into per-operand sign-extension bits.
  always_comb begin
    op   = mul_op_t'(in_op);
    a_sx = 1'b0;
    b_sx = 1'b0;
    case (op)
      MULH: begin
        a_sx = in_a[XLEN-1];
        b_sx = in_b[XLEN-1];
      end
      MULHSU: a_sx = in_a[XLEN-1];
      default: ;
    endcase
  end

  // Full-width multiply ahead of stage 1; the low 2*XLEN bits of the
  // extended product equal the signed product of the (XLEN+1)-bit operands.
  always_comb begin
    a_wide  = {{XLEN{a_sx}}, in_a};
    b_wide  = {{XLEN{b_sx}}, in_b};
    product = a_wide * b_wide;
    sel     = (op == MUL) ? product[XLEN-1:0] : product[PW-1:XLEN];
  end

  // Global flow control: the whole pipe moves together unless the tail is blocked.
  always_comb begin
    stall    = vq[STAGES-1] & ~out_ready;
    en       = ~stall;
    in_ready = ~stall;
    accept   = in_valid & in_ready;
  end

  // Stage chain: stage 1 captures the selected half, later stages just shift.
  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      mul_pipe_reg #(.W(XLEN)) u_reg (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .in_valid  (accept),
        .in_data   (sel),
        .out_valid (vq[i]),
        .out_data  (dq[i])
      );
    end else begin : g_next
      mul_pipe_reg #(.W(XLEN)) u_reg (
        .clock     (clock),
        .reset     (reset),
        .en        (en),
        .flush     (flush),
        .in_valid  (vq[i-1]),
        .in_data   (dq[i-1]),
        .out_valid (vq[i]),
        .out_data  (dq[i])
      );
    end
  end

  // Output view of the tail stage and occupancy.
  always_comb begin
    out_valid = vq[STAGES-1];
    out_res   = dq[STAGES-1];
    busy      = |vq;
  end

endmodule

// File: tb/tb_mul_pipe.sv
// Directed scoreboard bench for mul_pipe (XLEN=32, STAGES=3).
module tb_mul_pipe;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STAGES = 3;

  logic            clock = 1'b0;
  logic            reset;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_res;
  logic            busy;

  mul_pipe #(.XLEN(XLEN), .STAGES(STAGES)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_out    = 0;
  int last_out_cyc = -1;
  int first_out_cyc = -1;
  logic acc;
  logic [XLEN-1:0] q[$];
  logic [XLEN-1:0] out_log[$];

  // Reference: explicit (XLEN+1)-bit signed operands and a wide signed product.
  function automatic logic [XLEN-1:0] model(input logic [1:0] op,
                                            input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic signed [XLEN:0]     ea;
    logic signed [XLEN:0]     eb;
    logic signed [2*XLEN+1:0] p;
    ea = {((op == 2'd1) || (op == 2'd2)) ? a[XLEN-1] : 1'b0, a};
    eb = {(op == 2'd1) ? b[XLEN-1] : 1'b0, b};
    p  = ea * eb;
    return (op == 2'd0) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
  endfunction

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: sample at the falling edge, update the scoreboard, step past the rising edge.
  task automatic cycle();
    @(negedge clock);
    if (out_valid && out_ready) begin
      chk("out_has_request", XLEN'(q.size() != 0), XLEN'(1));
      if (q.size() != 0) chk("out_res_order", out_res, q.pop_front());
      out_log.push_back(out_res);
      n_out++;
      last_out_cyc = cyc;
      if (first_out_cyc < 0) first_out_cyc = cyc;
    end
    if (flush) q.delete();
    acc = in_valid && in_ready;
    if (acc && !flush) q.push_back(model(in_op, in_a, in_b));
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) cycle();
    chk("drain_empty", XLEN'(q.size()), XLEN'(0));
  endtask

  task automatic clear_log();
    n_out = 0;
    first_out_cyc = -1;
    last_out_cyc = -1;
    out_log.delete();
  endtask

  int acc_cyc;
  int n_acc;
  logic [XLEN-1:0] snap;

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 2'd0;
    in_a = '0; in_b = '0; out_ready = 1'b1;

    // Reset state
    #12;
    chk("rst_out_valid", XLEN'(out_valid), XLEN'(0));
    chk("rst_busy", XLEN'(busy), XLEN'(0));
    chk("rst_out_res", out_res, XLEN'(0));
    @(posedge clock); #3 reset = 1'b0; #1;
    chk("rst_in_ready", XLEN'(in_ready), XLEN'(1));

    // Single MUL: latency and value
    clear_log();
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'h0000_0007; in_b = 32'hFFFF_FFFD;
    cycle();
    acc_cyc = cyc - 1;
    in_valid = 1'b0;
    for (int i = 0; i < 10 && n_out == 0; i++) cycle();
    chk("mul_latency", XLEN'(last_out_cyc - acc_cyc), XLEN'(STAGES));
    chk("mul_value", (out_log.size() != 0) ? out_log[0] : '0, 32'hFFFF_FFEB);
    drain();

    // High-half ops back to back
    clear_log();
    in_valid = 1'b1;
    in_op = 2'd1; in_a = 32'h8000_0000; in_b = 32'h8000_0000; cycle();
    in_op = 2'd2; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; cycle();
    in_op = 2'd3; cycle();
    in_valid = 1'b0;
    drain();
    chk("hi_count", XLEN'(out_log.size()), XLEN'(3));
    if (out_log.size() == 3) begin
      chk("mulh", out_log[0], 32'h4000_0000);
      chk("mulhsu", out_log[1], 32'hFFFF_FFFF);
      chk("mulhu", out_log[2], 32'hFFFF_FFFE);
    end

    // Eight back-to-back requests at full rate
    clear_log();
    acc_cyc = cyc;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_op = 2'($urandom_range(0, 3));
      in_a = $urandom; in_b = $urandom;
      chk("stream_in_ready", XLEN'(in_ready), XLEN'(1));
      cycle();
    end
    in_valid = 1'b0;
    drain();
    chk("stream_count", XLEN'(n_out), XLEN'(8));
    chk("stream_first", XLEN'(first_out_cyc - acc_cyc), XLEN'(STAGES));
    chk("stream_span", XLEN'(last_out_cyc - first_out_cyc), XLEN'(7));

    // Backpressure: fill the pipe, stall 5 cycles, release
    clear_log();
    out_ready = 1'b0;
    n_acc = 0;
    in_valid = 1'b1; in_op = 2'd1; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0;
    for (int i = 0; i < 20 && n_acc < 3; i++) begin
      cycle();
      if (acc) begin
        n_acc++;
        in_op = in_op + 2'd1;
        in_a = in_a + 32'h1111_1111;
        in_b = in_b - 32'h0F0F_0F0F;
      end
    end
    chk("stall_fill", XLEN'(n_acc), XLEN'(3));
    snap = out_res;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", XLEN'(in_ready), XLEN'(0));
      chk("stall_out_valid", XLEN'(out_valid), XLEN'(1));
      chk("stall_out_res", out_res, snap);
      cycle();
    end
    out_ready = 1'b1;
    cycle();
    chk("release_accept", XLEN'(acc), XLEN'(1));
    in_valid = 1'b0;
    drain();
    chk("stall_count", XLEN'(n_out), XLEN'(4));

    // Flush with three in flight plus a same-cycle accept
    clear_log();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_op = 2'(i); in_a = $urandom; in_b = $urandom;
      cycle();
    end
    in_op = 2'd3; in_a = 32'hDEAD_BEEF; in_b = 32'hCAFE_F00D;
    flush = 1'b1;
    cycle();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_busy", XLEN'(busy), XLEN'(0));
    chk("flush_consumed", XLEN'(n_out), XLEN'(1));
    for (int i = 0; i < 10; i++) begin
      chk("flush_no_out", XLEN'(out_valid), XLEN'(0));
      cycle();
    end

    // Asynchronous reset mid-stream
    clear_log();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_op = 2'(i); in_a = $urandom; in_b = $urandom;
      cycle();
    end
    chk("pre_reset_valid", XLEN'(out_valid), XLEN'(1));
    #2 reset = 1'b1;
    #1;
    chk("async_out_valid", XLEN'(out_valid), XLEN'(0));
    chk("async_busy", XLEN'(busy), XLEN'(0));
    chk("async_out_res", out_res, XLEN'(0));
    q.delete();
    in_valid = 1'b0;
    @(posedge clock); @(posedge clock); #3 reset = 1'b0; #1;
    chk("post_reset_in_ready", XLEN'(in_ready), XLEN'(1));
    for (int i = 0; i < 10; i++) begin
      chk("post_reset_no_out", XLEN'(out_valid), XLEN'(0));
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_pipe.md
MUL_PIPE -- requirements
Module: mul_pipe

Interface
REQ-001 Parameter XLEN, default 32, sets the operand and result width; legal values are 32 and 64.
REQ-002 Parameter STAGES, default 3, sets the pipeline depth in registers; legal range is 1..4.
REQ-003 clock  in  1  Single clock; all state updates on its rising edge.
REQ-004 reset  in  1  Asynchronous, active-high reset.
REQ-005 flush  in  1  Kills every in-flight operation and any operation handshaked in the same cycle.
REQ-006 in_valid  in  1  Request valid.
REQ-007 in_ready  out  1  The pipeline can accept a request this cycle.
REQ-008 in_op  in  2  Operation: 0=MUL (low), 1=MULH (s*s, high), 2=MULHSU (s*u, high), 3=MULHU (u*u, high).
REQ-009 in_a, in_b  in  XLEN  Operands.
REQ-010 out_valid  out  1  Result valid.
REQ-011 out_ready  in  1  Consumer accepts the result.
REQ-012 out_res  out  XLEN  Selected result half.
REQ-013 busy  out  1  OR of all stage valid bits.

Function
REQ-014 The block SHALL hold one valid bit per stage, v[1..STAGES]; out_valid SHALL equal v[STAGES].
REQ-015 stall SHALL equal v[STAGES] & ~out_ready; the whole pipeline SHALL advance only when stall is 0.
REQ-016 in_ready SHALL equal ~stall, with no combinational dependence on in_valid.
REQ-017 Accept SHALL be in_valid & in_ready; v[1] SHALL load accept & ~flush when advancing.
REQ-018 Operand A SHALL be sign-extended by one bit when in_op is 1 or 2, else zero-extended; operand B SHALL be sign-extended when in_op is 1, else zero-extended; the product SHALL be the 2*XLEN-bit signed product.
REQ-019 out_res SHALL be product[XLEN-1:0] for op 0 and product[2*XLEN-1:XLEN] for ops 1-3.
REQ-020 Latency: a request accepted at cycle T SHALL present out_valid at T+STAGES when no stall occurs; throughput SHALL be one result per cycle.
REQ-021 During a stall, all stage valid and data registers SHALL hold, and out_res SHALL remain stable while out_valid is 1.
REQ-022 flush SHALL clear every v[] bit at the next edge regardless of stall; a result handshaked in the flush cycle is consumed, and an input handshaked in the flush cycle is dropped.
REQ-023 A result SHALL NOT appear on out_valid without a corresponding accepted, unflushed request; results SHALL leave in acceptance order.
REQ-024 With v[STAGES]=1 and out_ready=1, a new accept in the same cycle SHALL be legal (full-rate streaming).
REQ-025 Data registers of stages whose valid bit is 0 SHALL NOT influence out_res while out_valid is 1.

Reset
REQ-026 Reset SHALL asynchronously clear all v[] bits, giving out_valid=0 and busy=0, and in_ready SHALL read 1 once reset deasserts.
REQ-027 Reset SHALL clear the data registers to 0, so out_res reads 0 after reset.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight operations, with no output after release.

Structure
REQ-029 Package mul_pkg SHALL hold the mul_op_t enum (MUL, MULH, MULHSU, MULHU) and the parameter defaults.
REQ-030 One sub-module, mul_pipe_reg, SHALL implement a single valid+data stage with en (~stall), flush and asynchronous reset; mul_pipe SHALL instantiate it STAGES times.
REQ-031 The multiply SHALL be computed before stage 1; the remaining stages SHALL be plain registers so that synthesis can retime them.

Verification
REQ-032 STAGES=3, MUL a=0x0000_0007 b=0xFFFF_FFFD at T -> out_valid at T+3, out_res=0xFFFF_FFEB.
REQ-033 MULH 0x8000_0000*0x8000_0000 -> 0x4000_0000; MULHSU 0xFFFF_FFFF*0xFFFF_FFFF -> 0xFFFF_FFFF; MULHU same operands -> 0xFFFF_FFFE.
REQ-034 Stream 8 back-to-back requests with out_ready=1 -> 8 consecutive out_valid cycles, in order, with in_ready never 0.
REQ-035 Hold out_ready=0 for 5 cycles with a full pipe -> in_ready=0, out_res stable; on release, results drain in order with no loss or duplication.
REQ-036 flush with 3 in flight plus a same-cycle accept -> next cycle busy=0, and no out_valid within 10 cycles.
REQ-037 Assert reset asynchronously mid-stream (between edges) -> out_valid falls immediately, and no stale results appear after release.
